// File: rtl/alu_trace_recorder.sv
// Captures ALU transactions from a valid/ready port and writes them into a byte
// memory as 4-byte test-vector records, then closes the image with an FF terminator.
module alu_trace_recorder #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int MAX_REC = DEPTH/4-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opc,
  input  logic [7:0]        in_v1,
  input  logic [7:0]        in_v2,
  input  logic [7:0]        in_out,
  input  logic              finish,
  output logic              done,
  output logic [ADDR_W-2:0] rec_count,
  output logic              overflow,
  output logic              term_clash,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  typedef enum logic [1:0] {IDLE, WRITE, TERM, DONE} state_t;

  localparam logic [ADDR_W-2:0] MAX_REC_C = (ADDR_W-1)'(MAX_REC);

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic [1:0]        byte_cnt;
  logic [2:0]        lat_opc;
  logic [7:0]        lat_v1, lat_v2, lat_out;
  logic              pending;
  logic              full, accept, last_byte, wr_en;
  logic [7:0]        wr_byte;
  logic [7:0]        mem [DEPTH];

  // A finish request in the same IDLE cycle as a valid transaction takes priority.
  assign full      = (rec_count == MAX_REC_C);
  assign in_ready  = (state == IDLE) && !done && !full && !pending && !finish;
  assign accept    = in_valid && in_ready;
  assign last_byte = (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (finish)      state_next = TERM;
        else if (accept) state_next = WRITE;
      end
      WRITE: begin
        if (last_byte) state_next = (pending || finish) ? TERM : IDLE;
      end
      TERM: begin
        if (last_byte) state_next = DONE;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = (state == WRITE) || (state == TERM);
    wr_byte = 8'hFF;
    if (state == WRITE) begin
      case (byte_cnt)
        2'd0:    wr_byte = {5'b0, lat_opc};
        2'd1:    wr_byte = lat_v1;
        2'd2:    wr_byte = lat_v2;
        default: wr_byte = lat_out;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      byte_cnt   <= '0;
      rec_count  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      term_clash <= 1'b0;
      pending    <= 1'b0;
      lat_opc    <= '0;
      lat_v1     <= '0;
      lat_v2     <= '0;
      lat_out    <= '0;
    end else begin
      if (accept) begin
        lat_opc  <= in_opc;
        lat_v1   <= in_v1;
        lat_v2   <= in_v2;
        lat_out  <= in_out;
        byte_cnt <= 2'd0;
        if (in_v1 == 8'hFF && in_v2 == 8'hFF && in_out == 8'hFF)
          term_clash <= 1'b1;
      end
      if (state == IDLE && full && in_valid)
        overflow <= 1'b1;
      if (state == IDLE && finish)
        byte_cnt <= 2'd0;
      if (wr_en) begin
        wr_ptr   <= wr_ptr + ADDR_W'(1);
        byte_cnt <= byte_cnt + 2'd1;
      end
      // A finish arriving on the final record byte goes straight to TERM, so pending clears there too.
      if (state == WRITE) begin
        if (finish) pending <= 1'b1;
        if (last_byte) begin
          rec_count <= rec_count + (ADDR_W-1)'(1);
          pending   <= 1'b0;
        end
      end
      if (state == TERM && last_byte)
        done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/alu_trace_recorder.md
Name: alu_trace_recorder

Overview:
- Captures ALU transactions (opcode, operands, result) presented on a valid/ready interface.
- Serialises each transaction into a byte-wide memory in the team's 4-byte test-vector record format: byte0={5'b0,opc}, byte1=v1, byte2=v2, byte3=result.
- Closes the image with the FF FF FF FF terminator record.
- Produces, from live hardware, the vector images the ALU benches consume; a readback port lets a bench or host dump the image.

Parameters:
- DEPTH, 64, memory size in bytes; must be a multiple of 4 and at least 8.
- ADDR_W, 6, address width; 2**ADDR_W >= DEPTH.
- MAX_REC, DEPTH/4-1, data records accepted before full; one slot is reserved for the terminator.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  transaction present
- in_ready  out  1  recorder can accept a transaction this cycle
- in_opc  in  3  ALU opcode
- in_v1  in  8  operand 1
- in_v2  in  8  operand 2
- in_out  in  8  ALU result
- finish  in  1  request terminator write and close the image
- done  out  1  image closed (terminator written)
- rec_count  out  ADDR_W-1  data records stored
- overflow  out  1  sticky: valid presented while full
- term_clash  out  1  sticky: a stored record has v1=v2=result=FF
- rd_addr  in  ADDR_W  readback byte address
- rd_data  out  8  readback byte, registered, 1-cycle latency

Behaviour:
- Reset, sampled on the clk edge with rst=1: state=IDLE, write pointer=0, rec_count=0, done=0, overflow=0, term_clash=0, pending-finish=0, rd_data=0. Memory contents are not cleared.
- FSM states: IDLE, WRITE, TERM, DONE.
- in_ready = (state==IDLE) && !done && (rec_count<MAX_REC) && !pending-finish.
- Accept occurs on edge k when in_valid && in_ready.
  - The four fields are latched; state goes to WRITE with byte counter=0.
- WRITE: one byte per cycle at the write pointer, on edges k+1..k+4, in order byte0..byte3.
  - The pointer increments on each write.
  - At edge k+4: rec_count increments and state goes to IDLE, or to TERM if pending-finish is set.
  - in_ready is low during cycles k+1..k+4; maximum throughput is 1 record per 5 cycles.
- Inputs change freely after acceptance; only the latched copy is written.
- finish:
  - In IDLE: go to TERM.
  - In WRITE: set pending-finish; TERM follows record completion.
  - In TERM/DONE: ignored.
  - finish and accept in the same IDLE cycle: finish wins; the transaction is not accepted (in_ready is treated as 0 that cycle).
- TERM: writes FF at 4 consecutive addresses over 4 cycles, then goes to DONE.
- DONE: done=1, in_ready=0; held until rst.
- Full (rec_count==MAX_REC) in IDLE: in_ready=0. in_valid=1 sets overflow; the transaction is dropped. finish still writes the terminator into the reserved slot.
- term_clash: set at acceptance if in_v1==FF && in_v2==FF && in_out==FF. The record is still stored; the flag warns that the reader would treat it as end-of-image.
- Readback: rd_data <= mem[rd_addr] on every edge.
  - Read of an address written on the same edge returns the old byte.
  - Reads of unwritten addresses are undefined.
- rst mid-WRITE or mid-TERM: the record is abandoned and pointers return to 0. Partially written bytes remain in memory but are not counted.

Test Plan:
- Reset, then one transaction opc=3 v1=12 v2=34 out=46 accepted at edge k:
  - in_ready low for 4 cycles, rec_count=1.
  - Readback addresses 0..3 = 03 12 34 46.
- Two back-to-back records (valid held high), then finish:
  - Second accept exactly 5 cycles after the first; done asserts 4 cycles after TERM entry.
  - Addresses 4..7 hold record 2; addresses 8..11 = FF FF FF FF.
- finish asserted on the second WRITE cycle of a record:
  - Record completes intact, terminator follows at addresses 4..7, done=1.
  - in_valid after done gets in_ready=0 and no write.
- DEPTH=64, 15 records:
  - rec_count=15, in_ready=0.
  - A 16th valid sets overflow=1 and no memory change.
  - finish writes FF at addresses 60..63.
- Record opc=5 v1=FF v2=FF out=FF:
  - term_clash=1; bytes 05 FF FF FF stored; rec_count increments.
- rst asserted on the third WRITE cycle:
  - Next cycle rec_count=0, in_ready=1.
  - A new record opc=1 v1=01 v2=01 out=02 lands at addresses 0..3.
